// File: rtl/wform_arb_pkg.sv
// ---------------------------------------------------------------------------
// wform_arb_pkg
// Shared definitions for the waveform bus arbiter:
//   - Wishbone field widths (address, data, byte select)
//   - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package wform_arb_pkg;

    localparam int WB_ADR_WID = 32;
    localparam int WB_DAT_WID = 32;
    localparam int WB_SEL_WID = 4;

    // ABORT is only reachable when the slave-timeout feature is built in.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ABORT   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wform_rr_pick.sv
// ---------------------------------------------------------------------------
// wform_rr_pick
// Combinational round-robin picker. Starting at last+1 and wrapping, it
// returns the first requesting master as a one-hot vector (all-zero if no
// request).
// Ports:
//   req  [NUM_MASTERS-1:0]  request vector, bit i = master i
//   last [IDX_WID-1:0]      index of the previous owner
//   pick [NUM_MASTERS-1:0]  one-hot winner
// ---------------------------------------------------------------------------
module wform_rr_pick #(
    parameter int NUM_MASTERS = 3,
    parameter int IDX_WID     = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_WID-1:0]     last,
    output logic [NUM_MASTERS-1:0] pick
);

    int   idx;
    logic found;
    logic hit;

    // Walk the masters in priority order; the first requester found wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        hit   = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx       = (int'(last) + k) % NUM_MASTERS;
            hit       = req[idx] & ~found;
            pick[idx] = hit;
            found     = found | hit;
        end
    end

endmodule

// File: rtl/wform_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wform_bus_arbiter
// Round-robin arbiter letting NUM_MASTERS Wishbone masters share one slave
// port (SPI master / waveform RAM). The owner keeps the bus while its m_cyc
// stays high; every hand-over passes through at least one IDLE cycle.
//
// Optional feature (macro WFORM_ARB_TIMEOUT_EN): a slave-ack timeout. After
// TIMEOUT_CYCLES strobed cycles without s_ack the owner gets a one-cycle
// m_err pulse and the arbiter parks in ABORT until the owner drops m_cyc.
// Without the macro m_err is tied low and the arbiter waits forever.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   m_cyc/m_stb/m_we [N]         per-master controls
//   m_sel [4N], m_adr/m_dat_w [32N]  packed per-master fields
//   m_dat_r [32], m_ack [N], m_err [N]  responses to the masters
//   s_cyc/s_stb/s_we, s_sel, s_adr, s_dat_w  shared slave request
//   s_dat_r, s_ack               shared slave response
//   grant [N]                    registered one-hot owner
//   busy                         state is not IDLE
// ---------------------------------------------------------------------------
module wform_bus_arbiter
    import wform_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WID    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [WB_SEL_WID*NUM_MASTERS-1:0] m_sel,
    input  logic [WB_ADR_WID*NUM_MASTERS-1:0] m_adr,
    input  logic [WB_DAT_WID*NUM_MASTERS-1:0] m_dat_w,
    output logic [WB_DAT_WID-1:0]             m_dat_r,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [WB_SEL_WID-1:0]             s_sel,
    output logic [WB_ADR_WID-1:0]             s_adr,
    output logic [WB_DAT_WID-1:0]             s_dat_w,
    input  logic [WB_DAT_WID-1:0]             s_dat_r,
    input  logic                              s_ack,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              busy
);

    localparam int                 IDX_WID  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // last_grant resets to the top master so master 0 wins the first round.
    localparam logic [IDX_WID-1:0] LAST_RST = IDX_WID'(NUM_MASTERS - 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_WID < 1) begin : g_cfg_check
        $error("wform_bus_arbiter: unsupported parameter set");
    end

    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IDX_WID-1:0]     gidx_q;
    logic [IDX_WID-1:0]     last_q;
    logic                   busy_q;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [IDX_WID-1:0]     gidx_d;
    logic                   owner_cyc_s;

`ifdef WFORM_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_WID-1:0] TO_LAST = TIMEOUT_WID'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_WID-1:0] cnt_q;
    logic [NUM_MASTERS-1:0] err_q;
    assign m_err = err_q;
`else
    assign m_err = '0;
`endif

    wform_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_WID     (IDX_WID)
    ) u_pick (
        .req  (m_cyc),
        .last (last_q),
        .pick (grant_d)
    );

    // Encode the one-hot pick as an index for the registered mux select.
    always_comb begin
        gidx_d = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            gidx_d = gidx_d | (grant_d[i] ? IDX_WID'(i) : '0);
        end
    end

    assign owner_cyc_s = m_cyc[gidx_q];
    assign grant       = grant_q;
    assign busy        = busy_q;

    // Arbiter FSM: grant, last-owner bookkeeping and the optional timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            busy_q  <= 1'b0;
`ifdef WFORM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
`ifdef WFORM_ARB_TIMEOUT_EN
            err_q <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (|m_cyc) begin
                        state_q <= ST_GRANTED;
                        grant_q <= grant_d;
                        gidx_q  <= gidx_d;
                        busy_q  <= 1'b1;
                    end
                end
                ST_GRANTED: begin
                    if (!owner_cyc_s) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        last_q  <= gidx_q;
                        busy_q  <= 1'b0;
`ifdef WFORM_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (m_stb[gidx_q]) begin
                        if (s_ack) begin
                            cnt_q <= '0;
                        end else if (cnt_q == TO_LAST) begin
                            cnt_q   <= '0;
                            err_q   <= grant_q;
                            state_q <= ST_ABORT;
                        end else begin
                            cnt_q <= cnt_q + TIMEOUT_WID'(1);
                        end
`endif
                    end
                end
`ifdef WFORM_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    if (!owner_cyc_s) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        last_q  <= gidx_q;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Slave request and master response steering; everything is quiet
    // outside GRANTED, so an ack arriving in IDLE/ABORT is discarded.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        m_ack   = '0;
        m_dat_r = '0;
        case (state_q)
            ST_GRANTED: begin
                s_cyc   = m_cyc[gidx_q];
                s_stb   = m_stb[gidx_q];
                s_we    = m_we[gidx_q];
                s_sel   = m_sel[int'(gidx_q) * WB_SEL_WID +: WB_SEL_WID];
                s_adr   = m_adr[int'(gidx_q) * WB_ADR_WID +: WB_ADR_WID];
                s_dat_w = m_dat_w[int'(gidx_q) * WB_DAT_WID +: WB_DAT_WID];
                // An ack is forwarded only while the owner still holds cyc.
                m_ack   = grant_q & m_cyc & {NUM_MASTERS{s_ack}};
                m_dat_r = s_dat_r;
            end
            default: begin
                s_cyc = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wform_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wform_bus_arbiter
// Directed testbench for wform_bus_arbiter. Expected acks are queued when a
// slave response is driven; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_wform_bus_arbiter;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [4*N-1:0]    m_sel;
    logic [32*N-1:0]   m_adr, m_dat_w;
    logic [31:0]       m_dat_r;
    logic [N-1:0]      m_ack, m_err;
    logic              s_cyc, s_stb, s_we;
    logic [3:0]        s_sel;
    logic [31:0]       s_adr, s_dat_w, s_dat_r;
    logic              s_ack;
    logic [N-1:0]      grant;
    logic              busy;

    typedef struct {
        logic [N-1:0] ack;
        logic [31:0]  data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] adr_tab [N];
    logic [31:0] dat_tab [N];
    logic [3:0]  sel_tab [N];
    logic [N-1:0] we_tab;

    wform_bus_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_WID    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_sel   (m_sel),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_dat_r (m_dat_r),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_sel   (s_sel),
        .s_adr   (s_adr),
        .s_dat_w (s_dat_w),
        .s_dat_r (s_dat_r),
        .s_ack   (s_ack),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Observe the current cycle at negedge, then advance past the next posedge.
    task automatic nchk(input string name, input logic [N-1:0] g, input logic b);
        @(negedge clk);
        chk({name, "_grant"}, 32'(grant), 32'(g));
        chk({name, "_busy"}, 32'(busy), 32'(b));
        chk({name, "_err"}, 32'(m_err), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic nchk_slave(input string name, input int i);
        @(negedge clk);
        chk({name, "_scyc"}, 32'(s_cyc), 32'd1);
        chk({name, "_swe"}, 32'(s_we), 32'(we_tab[i]));
        chk({name, "_ssel"}, 32'(s_sel), 32'(sel_tab[i]));
        chk({name, "_sadr"}, s_adr, adr_tab[i]);
        chk({name, "_sdatw"}, s_dat_w, dat_tab[i]);
        @(posedge clk); #1;
    endtask

    // One-cycle slave ack; the expected master response is queued.
    task automatic do_ack(input int i, input logic [31:0] d);
        exp_t e;
        e.ack    = '0;
        e.ack[i] = 1'b1;
        e.data   = d;
        exp_q.push_back(e);
        s_ack   = 1'b1;
        s_dat_r = d;
        @(posedge clk); #1;
        s_ack   = 1'b0;
        s_dat_r = 32'd0;
    endtask

    // Scoreboard monitor: every ack seen must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (m_ack != '0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack got=%b exp=none", m_ack);
            end else begin
                e = exp_q.pop_front();
                chk("ack_vec", 32'(m_ack), 32'(e.ack));
                chk("ack_data", m_dat_r, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        we_tab = 3'b101;
        for (int i = 0; i < N; i++) begin
            adr_tab[i] = 32'h1000_0000 + 32'(i);
            dat_tab[i] = 32'hDA7A_0000 + 32'(i);
            m_adr[32*i +: 32]   = adr_tab[i];
            m_dat_w[32*i +: 32] = dat_tab[i];
        end
        sel_tab[0] = 4'hF;
        sel_tab[1] = 4'h3;
        sel_tab[2] = 4'hC;
        for (int i = 0; i < N; i++) m_sel[4*i +: 4] = sel_tab[i];
        m_we    = we_tab;

        // Reset holds everything quiet even with requests and an ack present.
        rst     = 1'b1;
        m_cyc   = 3'b111;
        m_stb   = 3'b111;
        s_ack   = 1'b1;
        s_dat_r = 32'h1234_5678;
        @(posedge clk); #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_scyc", 32'(s_cyc), 32'd0);
        chk("rst_mack", 32'(m_ack), 32'd0);
        chk("rst_merr", 32'(m_err), 32'd0);
        m_cyc   = 3'b000;
        m_stb   = 3'b000;
        s_ack   = 1'b0;
        s_dat_r = 32'd0;
        rst     = 1'b0;
        @(posedge clk); #1;

        // All three request: 0, idle, 1, idle, 2.
        m_cyc = 3'b111;
        m_stb = 3'b111;
        @(posedge clk); #1;
        nchk("rr_g0", 3'b001, 1'b1);
        nchk_slave("rr_s0", 0);
        do_ack(0, 32'hD000_0000);
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(posedge clk); #1;
        nchk("rr_idle0", 3'b000, 1'b0);
        nchk("rr_g1", 3'b010, 1'b1);
        nchk_slave("rr_s1", 1);
        do_ack(1, 32'hD000_0001);
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        @(posedge clk); #1;
        nchk("rr_idle1", 3'b000, 1'b0);
        nchk("rr_g2", 3'b100, 1'b1);
        nchk_slave("rr_s2", 2);
        do_ack(2, 32'hD000_0002);
        m_cyc = 3'b000;
        m_stb = 3'b000;
        @(posedge clk); #1;
        nchk("rr_idle2", 3'b000, 1'b0);

        // Master 1 alone: three reads under one held cycle.
        m_cyc = 3'b010;
        m_stb = 3'b010;
        m_we  = 3'b000;
        @(posedge clk); #1;
        nchk("b2b_g", 3'b010, 1'b1);
        do_ack(1, 32'hA5A5_0001);
        nchk("b2b_hold", 3'b010, 1'b1);
        do_ack(1, 32'hA5A5_0002);
        do_ack(1, 32'hA5A5_0003);
        nchk("b2b_end", 3'b010, 1'b1);
        // A late ack after cyc dropped must not reach the master.
        m_cyc = 3'b000;
        m_stb = 3'b000;
        s_ack = 1'b1;
        @(negedge clk);
        chk("late_ack", 32'(m_ack), 32'd0);
        @(posedge clk); #1;
        s_ack = 1'b0;
        nchk("solo_idle", 3'b000, 1'b0);
        m_cyc = 3'b010;
        m_stb = 3'b010;
        @(posedge clk); #1;
        nchk("solo_regrant", 3'b010, 1'b1);
        m_cyc = 3'b000;
        m_stb = 3'b000;
        @(posedge clk); #1;

        // Master 2 holds the bus for 20 cycles while master 0 waits.
        m_we  = we_tab;
        m_cyc = 3'b100;
        m_stb = 3'b100;
        @(posedge clk); #1;
        m_cyc = 3'b101;
        m_stb = 3'b101;
        for (int k = 0; k < 20; k++) nchk("hold", 3'b100, 1'b1);
        do_ack(2, 32'hC0DE_0002);
        m_cyc = 3'b001;
        m_stb = 3'b001;
        @(posedge clk); #1;
        nchk("hold_idle", 3'b000, 1'b0);
        nchk("hold_g0", 3'b001, 1'b1);
        do_ack(0, 32'hC0DE_0000);

        // Reset mid-transfer; master 0 must win afterwards, not master 1.
        m_cyc = 3'b010;
        m_stb = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_cyc = 3'b011;
        m_stb = 3'b011;
        chk("prerst_grant", 32'(grant), 32'(3'b010));
        chk("prerst_sstb", 32'(s_stb), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_scyc", 32'(s_cyc), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        nchk("postrst_g0", 3'b001, 1'b1);
        m_cyc = 3'b000;
        m_stb = 3'b000;
        @(posedge clk); #1;
        nchk("postrst_idle", 3'b000, 1'b0);

        // Slave never acks.
        m_cyc   = 3'b010;
        m_stb   = 3'b010;
        s_dat_r = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_scyc", 32'(s_cyc), 32'd1);
            chk("to_noerr", 32'(m_err), 32'd0);
            @(posedge clk); #1;
        end
`ifdef WFORM_ARB_TIMEOUT_EN
        @(negedge clk);
        chk("to_err", 32'(m_err), 32'(3'b010));
        chk("to_abort_scyc", 32'(s_cyc), 32'd0);
        chk("to_abort_dat", m_dat_r, 32'd0);
        chk("to_abort_grant", 32'(grant), 32'(3'b010));
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_err_clr", 32'(m_err), 32'd0);
            chk("abort_scyc", 32'(s_cyc), 32'd0);
            chk("abort_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
`else
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("wait_scyc", 32'(s_cyc), 32'd1);
            chk("wait_noerr", 32'(m_err), 32'd0);
            @(posedge clk); #1;
        end
`endif
        m_cyc   = 3'b000;
        m_stb   = 3'b000;
        s_dat_r = 32'd0;
        @(posedge clk); #1;
        nchk("to_idle", 3'b000, 1'b0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
